// File: rtl/axi4l_pkg.sv
// axi4l_pkg: shared AXI4-Lite constants and the
// state encoding of the axi4l_mif master FSM.
package axi4l_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_AW_W = 3'd1;
  localparam logic [2:0] S_WR_B    = 3'd2;
  localparam logic [2:0] S_RD_AR   = 3'd3;
  localparam logic [2:0] S_RD_R    = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

endpackage

// File: rtl/axi4l_mif_if.sv
// axi4l_mif_if: command/response port plus AXI4-Lite bus.
// master = the axi4l_mif side, slave = engine + peripheral.
interface axi4l_mif_if #(
  parameter int axi4l__addr_width = 32,
  parameter int axi4l__data_width = 32
);
  localparam int sw = axi4l__data_width / 8;

  logic                         acc__cmd_valid;
  logic                         acc__cmd_ready;
  logic                         acc__cmd_write;
  logic [axi4l__addr_width-1:0] acc__cmd_addr;
  logic [axi4l__data_width-1:0] acc__cmd_wdata;
  logic [sw-1:0]                acc__cmd_wstrb;
  logic                         acc__rsp_valid;
  logic                         acc__rsp_ready;
  logic                         acc__rsp_write;
  logic [axi4l__data_width-1:0] acc__rsp_rdata;
  logic [1:0]                   acc__rsp_resp;

  logic [axi4l__addr_width-1:0] axi4l__m_awaddr;
  logic [2:0]                   axi4l__m_awprot;
  logic                         axi4l__m_awvalid;
  logic                         axi4l__m_awready;
  logic [axi4l__data_width-1:0] axi4l__m_wdata;
  logic [sw-1:0]                axi4l__m_wstrb;
  logic                         axi4l__m_wvalid;
  logic                         axi4l__m_wready;
  logic [1:0]                   axi4l__m_bresp;
  logic                         axi4l__m_bvalid;
  logic                         axi4l__m_bready;
  logic [axi4l__addr_width-1:0] axi4l__m_araddr;
  logic [2:0]                   axi4l__m_arprot;
  logic                         axi4l__m_arvalid;
  logic                         axi4l__m_arready;
  logic [axi4l__data_width-1:0] axi4l__m_rdata;
  logic [1:0]                   axi4l__m_rresp;
  logic                         axi4l__m_rvalid;
  logic                         axi4l__m_rready;

  modport master (
    input  acc__cmd_valid, acc__cmd_write,
    input  acc__cmd_addr, acc__cmd_wdata,
    input  acc__cmd_wstrb, acc__rsp_ready,
    output acc__cmd_ready, acc__rsp_valid,
    output acc__rsp_write, acc__rsp_rdata,
    output acc__rsp_resp,
    output axi4l__m_awaddr, axi4l__m_awprot,
    output axi4l__m_awvalid,
    input  axi4l__m_awready,
    output axi4l__m_wdata, axi4l__m_wstrb,
    output axi4l__m_wvalid,
    input  axi4l__m_wready,
    input  axi4l__m_bresp, axi4l__m_bvalid,
    output axi4l__m_bready,
    output axi4l__m_araddr, axi4l__m_arprot,
    output axi4l__m_arvalid,
    input  axi4l__m_arready,
    input  axi4l__m_rdata, axi4l__m_rresp,
    input  axi4l__m_rvalid,
    output axi4l__m_rready
  );

  modport slave (
    output acc__cmd_valid, acc__cmd_write,
    output acc__cmd_addr, acc__cmd_wdata,
    output acc__cmd_wstrb, acc__rsp_ready,
    input  acc__cmd_ready, acc__rsp_valid,
    input  acc__rsp_write, acc__rsp_rdata,
    input  acc__rsp_resp,
    input  axi4l__m_awaddr, axi4l__m_awprot,
    input  axi4l__m_awvalid,
    output axi4l__m_awready,
    input  axi4l__m_wdata, axi4l__m_wstrb,
    input  axi4l__m_wvalid,
    output axi4l__m_wready,
    output axi4l__m_bresp, axi4l__m_bvalid,
    input  axi4l__m_bready,
    input  axi4l__m_araddr, axi4l__m_arprot,
    input  axi4l__m_arvalid,
    output axi4l__m_arready,
    output axi4l__m_rdata, axi4l__m_rresp,
    output axi4l__m_rvalid,
    input  axi4l__m_rready
  );

endinterface

// File: rtl/axi4l_mif.sv
// axi4l_mif: single-outstanding AXI4-Lite master that turns
// one-beat commands into AXI reads/writes; all outputs registered.
module axi4l_mif
  import axi4l_pkg::*;
#(
  parameter int         axi4l__addr_width = 32,
  parameter int         axi4l__data_width = 32,
  parameter logic [2:0] axi4l__prot       = 3'b000
) (
  input logic          clk,
  input logic          srstn,
  axi4l_mif_if.master  bus
);

  localparam int sw = axi4l__data_width / 8;

  logic [2:0] state, state_nxt;

  logic cmd_ready_q, cmd_ready_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic arvalid_q, arvalid_d;
  logic bready_q, bready_d;
  logic rready_q, rready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_write_q, rsp_write_d;
  logic [1:0] resp_q, resp_d;
  logic [axi4l__addr_width-1:0] addr_q, addr_d;
  logic [axi4l__data_width-1:0] wdata_q, wdata_d;
  logic [axi4l__data_width-1:0] rdata_q, rdata_d;
  logic [sw-1:0] wstrb_q, wstrb_d;

  // AW and W each count as done once their valid has dropped
  // or is being accepted this cycle.
  logic aw_ok, w_ok;
  assign aw_ok = !awvalid_q || bus.axi4l__m_awready;
  assign w_ok  = !wvalid_q || bus.axi4l__m_wready;

  // State register.
  always_ff @(posedge clk) begin
    if (!srstn) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode from current state and handshakes.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (bus.acc__cmd_valid)
          state_nxt = bus.acc__cmd_write ? S_WR_AW_W : S_RD_AR;
      S_WR_AW_W:
        if (aw_ok && w_ok) state_nxt = S_WR_B;
      S_WR_B:
        if (bus.axi4l__m_bvalid) state_nxt = S_RSP;
      S_RD_AR:
        if (bus.axi4l__m_arready) state_nxt = S_RD_R;
      S_RD_R:
        if (bus.axi4l__m_rvalid) state_nxt = S_RSP;
      S_RSP:
        if (bus.acc__rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of every registered output.
  always_comb begin
    cmd_ready_d = (state_nxt == S_IDLE);
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    resp_d      = resp_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    case (state)
      S_IDLE:
        if (bus.acc__cmd_valid) begin
          addr_d    = bus.acc__cmd_addr;
          wdata_d   = bus.acc__cmd_wdata;
          wstrb_d   = bus.acc__cmd_wstrb;
          awvalid_d = bus.acc__cmd_write;
          wvalid_d  = bus.acc__cmd_write;
          arvalid_d = !bus.acc__cmd_write;
        end
      S_WR_AW_W: begin
        if (bus.axi4l__m_awready) awvalid_d = 1'b0;
        if (bus.axi4l__m_wready)  wvalid_d  = 1'b0;
        if (aw_ok && w_ok)        bready_d  = 1'b1;
      end
      S_WR_B:
        if (bus.axi4l__m_bvalid) begin
          resp_d      = bus.axi4l__m_bresp;
          rdata_d     = '0;
          rsp_write_d = 1'b1;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
        end
      S_RD_AR:
        if (bus.axi4l__m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      S_RD_R:
        if (bus.axi4l__m_rvalid) begin
          resp_d      = bus.axi4l__m_rresp;
          rdata_d     = bus.axi4l__m_rdata;
          rsp_write_d = 1'b0;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
        end
      S_RSP:
        if (bus.acc__rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  // Output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      resp_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      resp_q      <= resp_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.acc__cmd_ready   = cmd_ready_q;
  assign bus.acc__rsp_valid   = rsp_valid_q;
  assign bus.acc__rsp_write   = rsp_write_q;
  assign bus.acc__rsp_rdata   = rdata_q;
  assign bus.acc__rsp_resp    = resp_q;
  assign bus.axi4l__m_awaddr  = addr_q;
  assign bus.axi4l__m_awprot  = axi4l__prot;
  assign bus.axi4l__m_awvalid = awvalid_q;
  assign bus.axi4l__m_wdata   = wdata_q;
  assign bus.axi4l__m_wstrb   = wstrb_q;
  assign bus.axi4l__m_wvalid  = wvalid_q;
  assign bus.axi4l__m_bready  = bready_q;
  assign bus.axi4l__m_araddr  = addr_q;
  assign bus.axi4l__m_arprot  = axi4l__prot;
  assign bus.axi4l__m_arvalid = arvalid_q;
  assign bus.axi4l__m_rready  = rready_q;

endmodule

// File: tb/tb_axi4l_mif.sv
// tb_axi4l_mif: directed and randomized bench for axi4l_mif
// with a delay-configurable AXI4-Lite slave and memory model.
module tb_axi4l_mif;

  logic clk = 1'b0;
  logic srstn = 1'b0;
  always #5 clk = ~clk;

  axi4l_mif_if #(
    .axi4l__addr_width(32),
    .axi4l__data_width(32)
  ) bus ();

  axi4l_mif #(
    .axi4l__addr_width(32),
    .axi4l__data_width(32),
    .axi4l__prot(3'b000)
  ) dut (
    .clk(clk),
    .srstn(srstn),
    .bus(bus)
  );

  int check_cnt = 0;
  int pass_cnt = 0;

  int aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_dly = 0, r_dly = 0;
  int resp_ovr = 0;
  bit rst_flag = 1'b0;
  int stab_err = 0;

  logic [31:0] smem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];
  logic [31:0] aw_q [$];
  logic [31:0] ar_q [$];
  logic [35:0] w_q [$];

  function automatic int dly(int d);
    return (d < 0) ? int'($urandom_range(0, 4)) : d;
  endfunction

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [1:0] resp_of(logic [31:0] a);
    return (resp_ovr >= 0) ? 2'(resp_ovr) : a[3:2];
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    if (mmem.exists(a)) return mmem[a];
    return init_word(a);
  endfunction

  function automatic void model_write(logic [31:0] a,
                                      logic [31:0] d,
                                      logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    mmem[a] = (model_read(a) & ~m) | (d & m);
  endfunction

  task automatic finish_run();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not end, got running exp done");
    check_cnt++;
    finish_run();
  end

  // Slave AW channel: accept after a delay, checking hold/stability.
  logic [31:0] aw_a;
  int aw_d;
  bit aw_ab;
  initial begin
    bus.axi4l__m_awready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.axi4l__m_awvalid === 1'b1) begin
        aw_a = bus.axi4l__m_awaddr;
        aw_d = dly(aw_dly);
        aw_ab = 1'b0;
        for (int i = 0; i < aw_d; i++) begin
          @(negedge clk);
          if (bus.axi4l__m_awvalid !== 1'b1) begin
            if (!rst_flag) stab_err++;
            aw_ab = 1'b1;
            break;
          end
          if (bus.axi4l__m_awaddr !== aw_a) stab_err++;
        end
        if (!aw_ab) begin
          bus.axi4l__m_awready = 1'b1;
          aw_q.push_back(aw_a);
          @(negedge clk);
          bus.axi4l__m_awready = 1'b0;
        end
      end
    end
  end

  // Slave W channel.
  logic [35:0] w_v;
  int w_d;
  bit w_ab;
  initial begin
    bus.axi4l__m_wready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.axi4l__m_wvalid === 1'b1) begin
        w_v = {bus.axi4l__m_wstrb, bus.axi4l__m_wdata};
        w_d = dly(w_dly);
        w_ab = 1'b0;
        for (int i = 0; i < w_d; i++) begin
          @(negedge clk);
          if (bus.axi4l__m_wvalid !== 1'b1) begin
            if (!rst_flag) stab_err++;
            w_ab = 1'b1;
            break;
          end
          if ({bus.axi4l__m_wstrb, bus.axi4l__m_wdata} !== w_v)
            stab_err++;
        end
        if (!w_ab) begin
          bus.axi4l__m_wready = 1'b1;
          w_q.push_back(w_v);
          @(negedge clk);
          bus.axi4l__m_wready = 1'b0;
        end
      end
    end
  end

  // Slave B channel: commit the write, then answer.
  logic [31:0] b_a;
  logic [35:0] b_v;
  int b_d;
  initial begin
    bus.axi4l__m_bvalid = 1'b0;
    bus.axi4l__m_bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (bus.axi4l__m_bready === 1'b1) begin
        b_d = dly(b_dly);
        repeat (b_d) @(negedge clk);
        if (bus.axi4l__m_bready === 1'b1) begin
          if (aw_q.size() == 0 || w_q.size() == 0) begin
            stab_err++;
          end else begin
            b_a = aw_q.pop_front();
            b_v = w_q.pop_front();
            if (!smem.exists(b_a)) smem[b_a] = init_word(b_a);
            for (int k = 0; k < 4; k++)
              if (b_v[32+k]) smem[b_a][8*k +: 8] = b_v[8*k +: 8];
            bus.axi4l__m_bresp = resp_of(b_a);
          end
          bus.axi4l__m_bvalid = 1'b1;
          @(negedge clk);
          bus.axi4l__m_bvalid = 1'b0;
        end
      end
    end
  end

  // Slave AR channel.
  logic [31:0] ar_a;
  int ar_d;
  bit ar_ab;
  initial begin
    bus.axi4l__m_arready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.axi4l__m_arvalid === 1'b1) begin
        ar_a = bus.axi4l__m_araddr;
        ar_d = dly(ar_dly);
        ar_ab = 1'b0;
        for (int i = 0; i < ar_d; i++) begin
          @(negedge clk);
          if (bus.axi4l__m_arvalid !== 1'b1) begin
            if (!rst_flag) stab_err++;
            ar_ab = 1'b1;
            break;
          end
          if (bus.axi4l__m_araddr !== ar_a) stab_err++;
        end
        if (!ar_ab) begin
          bus.axi4l__m_arready = 1'b1;
          ar_q.push_back(ar_a);
          @(negedge clk);
          bus.axi4l__m_arready = 1'b0;
        end
      end
    end
  end

  // Slave R channel: return stored word.
  logic [31:0] r_a;
  int r_d;
  initial begin
    bus.axi4l__m_rvalid = 1'b0;
    bus.axi4l__m_rdata = '0;
    bus.axi4l__m_rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (bus.axi4l__m_rready === 1'b1) begin
        r_d = dly(r_dly);
        repeat (r_d) @(negedge clk);
        if (bus.axi4l__m_rready === 1'b1) begin
          if (ar_q.size() == 0) begin
            stab_err++;
          end else begin
            r_a = ar_q.pop_front();
            bus.axi4l__m_rdata =
              smem.exists(r_a) ? smem[r_a] : init_word(r_a);
            bus.axi4l__m_rresp = resp_of(r_a);
          end
          bus.axi4l__m_rvalid = 1'b1;
          @(negedge clk);
          bus.axi4l__m_rvalid = 1'b0;
        end
      end
    end
  end

  // Present a command; returns one cycle after its handshake.
  task automatic issue(input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output int waited);
    bus.acc__cmd_write = w;
    bus.acc__cmd_addr = a;
    bus.acc__cmd_wdata = d;
    bus.acc__cmd_wstrb = s;
    bus.acc__cmd_valid = 1'b1;
    waited = 0;
    while (bus.acc__cmd_ready !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > 200) begin
        $display("FAIL cmd_timeout: got no cmd_ready exp ready");
        check_cnt++;
        finish_run();
      end
    end
    @(negedge clk);
    bus.acc__cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (bus.acc__rsp_valid !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL rsp_timeout: got no rsp_valid exp valid");
        check_cnt++;
        finish_run();
      end
    end
  endtask

  task automatic test_reset();
    srstn = 1'b0;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({bus.acc__cmd_ready, bus.axi4l__m_awvalid,
         bus.axi4l__m_wvalid, bus.axi4l__m_arvalid,
         bus.axi4l__m_bready, bus.axi4l__m_rready,
         bus.acc__rsp_valid} !== 7'b1000000)
      $display("FAIL reset_ctl: got %b exp 1000000",
        {bus.acc__cmd_ready, bus.axi4l__m_awvalid,
         bus.axi4l__m_wvalid, bus.axi4l__m_arvalid,
         bus.axi4l__m_bready, bus.axi4l__m_rready,
         bus.acc__rsp_valid});
    else pass_cnt++;
    check_cnt++;
    if ({bus.acc__rsp_write, bus.acc__rsp_resp,
         bus.acc__rsp_rdata} !== 35'd0)
      $display("FAIL reset_rsp: got %h exp 0",
        {bus.acc__rsp_write, bus.acc__rsp_resp,
         bus.acc__rsp_rdata});
    else pass_cnt++;
    srstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_fast();
    int wt;
    aw_dly = 0; w_dly = 0; b_dly = 0; resp_ovr = 0;
    bus.acc__rsp_ready = 1'b1;
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, wt);
    check_cnt++;
    if ({bus.axi4l__m_awvalid, bus.axi4l__m_wvalid,
         bus.axi4l__m_awaddr, bus.axi4l__m_wdata,
         bus.axi4l__m_wstrb, bus.acc__cmd_ready} !==
        {2'b11, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0})
      $display("FAIL wfast_awv: got aw=%h w=%h s=%h exp 10 deadbeef f",
        bus.axi4l__m_awaddr, bus.axi4l__m_wdata,
        bus.axi4l__m_wstrb);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({bus.acc__rsp_valid, bus.axi4l__m_bready} !== 2'b01)
      $display("FAIL wfast_n2: got %b exp 01",
        {bus.acc__rsp_valid, bus.axi4l__m_bready});
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({bus.acc__rsp_valid, bus.acc__rsp_write,
         bus.acc__rsp_resp, bus.acc__rsp_rdata} !==
        {1'b1, 1'b1, 2'b00, 32'h0})
      $display("FAIL wfast_rsp: got %h exp %h",
        {bus.acc__rsp_valid, bus.acc__rsp_write,
         bus.acc__rsp_resp, bus.acc__rsp_rdata},
        {1'b1, 1'b1, 2'b00, 32'h0});
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({bus.acc__rsp_valid, bus.acc__cmd_ready} !== 2'b01)
      $display("FAIL wfast_idle: got %b exp 01",
        {bus.acc__rsp_valid, bus.acc__cmd_ready});
    else pass_cnt++;
  endtask

  task automatic test_write_w_first();
    int wt;
    logic [31:0] d;
    d = $urandom;
    aw_dly = 3; w_dly = 0; b_dly = 1; resp_ovr = 2;
    model_write(32'h20, d, 4'hF);
    issue(1'b1, 32'h20, d, 4'hF, wt);
    check_cnt++;
    if ({bus.axi4l__m_awvalid, bus.axi4l__m_wvalid} !== 2'b11)
      $display("FAIL wfirst_n1: got %b exp 11",
        {bus.axi4l__m_awvalid, bus.axi4l__m_wvalid});
    else pass_cnt++;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check_cnt++;
      if ({bus.axi4l__m_awvalid, bus.axi4l__m_wvalid,
           bus.axi4l__m_bready} !== 3'b100)
        $display("FAIL wfirst_hold%0d: got %b exp 100", k,
          {bus.axi4l__m_awvalid, bus.axi4l__m_wvalid,
           bus.axi4l__m_bready});
      else pass_cnt++;
    end
    @(negedge clk);
    check_cnt++;
    if ({bus.axi4l__m_awvalid, bus.axi4l__m_bready} !== 2'b01)
      $display("FAIL wfirst_n5: got %b exp 01",
        {bus.axi4l__m_awvalid, bus.axi4l__m_bready});
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (bus.acc__rsp_valid !== 1'b0)
      $display("FAIL wfirst_n6: got %b exp 0", bus.acc__rsp_valid);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({bus.acc__rsp_valid, bus.acc__rsp_write,
         bus.acc__rsp_resp, bus.acc__rsp_rdata} !==
        {1'b1, 1'b1, 2'b10, 32'h0})
      $display("FAIL wfirst_rsp: got %h exp %h",
        {bus.acc__rsp_valid, bus.acc__rsp_write,
         bus.acc__rsp_resp, bus.acc__rsp_rdata},
        {1'b1, 1'b1, 2'b10, 32'h0});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_read_delay();
    int wt;
    aw_dly = 0; w_dly = 0; b_dly = 0;
    ar_dly = 0; r_dly = 5; resp_ovr = 0;
    smem[32'h4] = 32'h0000002A;
    mmem[32'h4] = 32'h0000002A;
    issue(1'b0, 32'h4, 32'h0, 4'h0, wt);
    check_cnt++;
    if ({bus.axi4l__m_arvalid, bus.axi4l__m_araddr} !==
        {1'b1, 32'h4})
      $display("FAIL rd_ar: got %b %h exp 1 4",
        bus.axi4l__m_arvalid, bus.axi4l__m_araddr);
    else pass_cnt++;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      check_cnt++;
      if ({bus.axi4l__m_arvalid, bus.axi4l__m_rready,
           bus.acc__rsp_valid} !== 3'b010)
        $display("FAIL rd_wait%0d: got %b exp 010", k,
          {bus.axi4l__m_arvalid, bus.axi4l__m_rready,
           bus.acc__rsp_valid});
      else pass_cnt++;
    end
    @(negedge clk);
    check_cnt++;
    if ({bus.acc__rsp_valid, bus.axi4l__m_rready,
         bus.acc__rsp_write, bus.acc__rsp_resp,
         bus.acc__rsp_rdata} !==
        {1'b1, 1'b0, 1'b0, 2'b00, 32'h2A})
      $display("FAIL rd_rsp: got %h exp %h",
        {bus.acc__rsp_valid, bus.axi4l__m_rready,
         bus.acc__rsp_write, bus.acc__rsp_resp,
         bus.acc__rsp_rdata},
        {1'b1, 1'b0, 1'b0, 2'b00, 32'h2A});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int wt;
    logic [34:0] exp;
    ar_dly = 0; r_dly = 0; resp_ovr = 0;
    bus.acc__rsp_ready = 1'b0;
    exp = {1'b0, 2'b00, model_read(32'h8)};
    issue(1'b0, 32'h8, 32'h0, 4'h0, wt);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check_cnt++;
      if ({bus.acc__rsp_valid, bus.acc__cmd_ready,
           bus.acc__rsp_write, bus.acc__rsp_resp,
           bus.acc__rsp_rdata} !== {2'b10, exp})
        $display("FAIL bp_hold%0d: got %h exp %h", k,
          {bus.acc__rsp_valid, bus.acc__cmd_ready,
           bus.acc__rsp_write, bus.acc__rsp_resp,
           bus.acc__rsp_rdata}, {2'b10, exp});
      else pass_cnt++;
      if (k < 4) @(negedge clk);
    end
    bus.acc__rsp_ready = 1'b1;
    @(negedge clk);
    check_cnt++;
    if ({bus.acc__rsp_valid, bus.acc__cmd_ready} !== 2'b01)
      $display("FAIL bp_release: got %b exp 01",
        {bus.acc__rsp_valid, bus.acc__cmd_ready});
    else pass_cnt++;
    model_write(32'h30, 32'h12345678, 4'h5);
    issue(1'b1, 32'h30, 32'h12345678, 4'h5, wt);
    check_cnt++;
    if ({wt[7:0], bus.axi4l__m_awvalid, bus.acc__cmd_ready} !==
        {8'd0, 1'b1, 1'b0})
      $display("FAIL bp_next_cmd: got wait=%0d awv=%b exp 0 1",
        wt, bus.axi4l__m_awvalid);
    else pass_cnt++;
    wait_rsp();
    check_cnt++;
    if ({bus.acc__rsp_write, bus.acc__rsp_resp,
         bus.acc__rsp_rdata} !== {1'b1, 2'b00, 32'h0})
      $display("FAIL bp_wr_rsp: got %h exp %h",
        {bus.acc__rsp_write, bus.acc__rsp_resp,
         bus.acc__rsp_rdata}, {1'b1, 2'b00, 32'h0});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    int wt;
    logic [31:0] exp;
    ar_dly = 10; r_dly = 0; resp_ovr = 0;
    rst_flag = 1'b1;
    issue(1'b0, 32'h14, 32'h0, 4'h0, wt);
    check_cnt++;
    if (bus.axi4l__m_arvalid !== 1'b1)
      $display("FAIL rst_pre: got %b exp 1", bus.axi4l__m_arvalid);
    else pass_cnt++;
    srstn = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({bus.axi4l__m_arvalid, bus.acc__cmd_ready,
         bus.acc__rsp_valid, bus.axi4l__m_rready} !== 4'b0100)
      $display("FAIL rst_mid: got %b exp 0100",
        {bus.axi4l__m_arvalid, bus.acc__cmd_ready,
         bus.acc__rsp_valid, bus.axi4l__m_rready});
    else pass_cnt++;
    srstn = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({bus.acc__rsp_valid, bus.axi4l__m_arvalid} !== 2'b00)
      $display("FAIL rst_no_rsp: got %b exp 00",
        {bus.acc__rsp_valid, bus.axi4l__m_arvalid});
    else pass_cnt++;
    rst_flag = 1'b0;
    ar_dly = 0;
    exp = model_read(32'h14);
    issue(1'b0, 32'h14, 32'h0, 4'h0, wt);
    wait_rsp();
    check_cnt++;
    if ({bus.acc__rsp_write, bus.acc__rsp_resp,
         bus.acc__rsp_rdata} !== {1'b0, 2'b00, exp})
      $display("FAIL rst_after: got %h exp %h",
        {bus.acc__rsp_write, bus.acc__rsp_resp,
         bus.acc__rsp_rdata}, {1'b0, 2'b00, exp});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int wt;
    int n;
    int hold_err;
    bit w;
    logic [31:0] a, d;
    logic [3:0] s;
    logic [34:0] exp;
    aw_dly = -1; w_dly = -1; b_dly = -1;
    ar_dly = -1; r_dly = -1; resp_ovr = -1;
    hold_err = 0;
    for (int t = 0; t < 1000; t++) begin
      bus.acc__rsp_ready = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 15)) << 2;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if (w) begin
        model_write(a, d, s);
        exp = {1'b1, a[3:2], 32'h0};
      end else begin
        exp = {1'b0, a[3:2], model_read(a)};
      end
      issue(w, a, d, s, wt);
      n = 0;
      forever begin
        bus.acc__rsp_ready = 1'($urandom_range(0, 1));
        if (bus.acc__rsp_valid === 1'b1) begin
          if (bus.acc__rsp_ready) break;
          if ({bus.acc__rsp_write, bus.acc__rsp_resp,
               bus.acc__rsp_rdata} !== exp) hold_err++;
        end
        @(negedge clk);
        n++;
        if (n > 300) begin
          $display("FAIL rnd_timeout%0d: got no rsp exp rsp", t);
          check_cnt++;
          finish_run();
        end
      end
      check_cnt++;
      if ({bus.acc__rsp_write, bus.acc__rsp_resp,
           bus.acc__rsp_rdata} !== exp)
        $display("FAIL rnd_rsp%0d: got %h exp %h", t,
          {bus.acc__rsp_write, bus.acc__rsp_resp,
           bus.acc__rsp_rdata}, exp);
      else pass_cnt++;
      @(negedge clk);
    end
    bus.acc__rsp_ready = 1'b0;
    repeat (4) @(negedge clk);
    check_cnt++;
    if (hold_err !== 0)
      $display("FAIL rnd_rsp_hold: got %0d exp 0", hold_err);
    else pass_cnt++;
    check_cnt++;
    if (stab_err !== 0)
      $display("FAIL valid_stable: got %0d exp 0", stab_err);
    else pass_cnt++;
    check_cnt++;
    if ({bus.acc__cmd_ready, bus.acc__rsp_valid} !== 2'b10)
      $display("FAIL rnd_end_idle: got %b exp 10",
        {bus.acc__cmd_ready, bus.acc__rsp_valid});
    else pass_cnt++;
  endtask

  initial begin
    bus.acc__cmd_valid = 1'b0;
    bus.acc__cmd_write = 1'b0;
    bus.acc__cmd_addr = '0;
    bus.acc__cmd_wdata = '0;
    bus.acc__cmd_wstrb = '0;
    bus.acc__rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_fast();
    test_write_w_first();
    test_read_delay();
    test_backpressure();
    test_reset_mid_read();
    test_random();
    finish_run();
  end

endmodule

// File: doc/axi4l_mif.md
Name: axi4l_mif

Overview:
- AXI4-Lite master interface; the initiator-side counterpart of the team's AXI4-Lite slave interface.
- Converts a simple single-beat command/response port (acc__ side) into AXI4-Lite read and write transactions (axi4l__m_ side).
- Used by on-chip engines that must program or poll AXI4-Lite peripherals, such as reading counter registers.
- Strictly one outstanding transaction; all AXI outputs are registered.

Parameters:
axi4l__addr_width, 32, address width of cmd and AW/AR channels
axi4l__data_width, 32, data width; must be 32 or 64; wstrb width = data_width/8
axi4l__prot, 3'b000, constant driven on awprot/arprot

Ports:
clk  in  1  clock
srstn  in  1  synchronous active-low reset
acc__cmd_valid  in  1  command valid
acc__cmd_ready  out  1  command accepted when valid&ready
acc__cmd_write  in  1  1=write, 0=read
acc__cmd_addr  in  addr_width  byte address
acc__cmd_wdata  in  data_width  write data (ignored for reads)
acc__cmd_wstrb  in  data_width/8  write strobes (ignored for reads)
acc__rsp_valid  out  1  response valid
acc__rsp_ready  in  1  response accepted when valid&ready
acc__rsp_write  out  1  echo of cmd_write
acc__rsp_rdata  out  data_width  read data; 0 for writes
acc__rsp_resp  out  2  bresp or rresp as returned by the slave
axi4l__m_awaddr/awprot/awvalid out, awready in
axi4l__m_wdata/wstrb/wvalid out, wready in
axi4l__m_bresp in (2), bvalid in, bready out
axi4l__m_araddr/arprot/arvalid out, arready in
axi4l__m_rdata in, rresp in (2), rvalid in, rready out

Behaviour:
- Reset (srstn=0 at a clk edge) forces the following; all other registered outputs reset to 0.
  - State goes to IDLE.
  - awvalid, wvalid, arvalid, bready, rready and rsp_valid go to 0.
  - cmd_ready goes to 1.
- Reset mid-transaction abandons the transaction; no response is produced.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr/wdata/wstrb/write.
  - Write: go to WR_AW_W and set awvalid and wvalid at the next edge.
  - Read: go to RD_AR and set arvalid.
- WR_AW_W:
  - awvalid is held until awready is seen; it then clears.
  - wvalid is held until wready is seen, independently of awvalid.
  - Either handshake may complete first, or both in the same cycle.
  - Address, data and strobes are stable while the corresponding valid is high.
  - When both handshakes are done, go to WR_B with bready=1.
- WR_B: on bvalid, capture bresp into rsp_resp, set rsp_rdata=0 and rsp_write=1, clear bready, go to RSP.
- RD_AR: arvalid is held until arready; then clear arvalid, set rready=1 and go to RD_R.
- RD_R: on rvalid, capture rdata and rresp, set rsp_write=0, clear rready, go to RSP.
- RSP:
  - rsp_valid=1; rsp_* fields are stable until rsp_ready.
  - On rsp_ready, clear rsp_valid and go to IDLE.
- cmd_ready is 0 in every state except IDLE.
- Minimum latency, write: cmd handshake at cycle N; AW/W valid at N+1. With immediate ready and bvalid, rsp_valid rises at N+3.
- Minimum latency, read: rsp_valid rises at N+3 under the same conditions.
- Back-to-back: at least one IDLE cycle separates consecutive commands; the next command handshake can occur at the cycle after the rsp handshake.
- Valids never drop before their handshake. Ready/valid dependency: no output valid depends combinationally on any AXI input.
- Non-OKAY responses (SLVERR/DECERR) are passed through unchanged; no retry.
- No timeout: the block waits indefinitely for slave handshakes.

Decomposition:
- Shared package axi4l_pkg holds:
  - AXI resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - FSM state encoding localparams.
- No sub-module: the AW/W join is two flag registers inside the FSM.

Test Plan:
- Write, slave ready immediately: cmd addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, ready/bvalid immediate → awaddr=0x10 and wdata=0xDEADBEEF seen on one cycle; rsp_valid at N+3 with resp=00, rsp_write=1, rdata=0.
- Write, W before AW: wready at N+1, awready at N+4, bvalid at N+6 with bresp=10 → wvalid drops after N+1, awvalid holds to N+4, rsp_resp=2'b10.
- Read with rvalid delayed 5 cycles: addr=0x4, rdata=0x0000002A, rresp=00 → arvalid drops after arready; rready high until rvalid; rsp_rdata=0x2A, rsp_write=0.
- Response backpressure: rsp_ready low for 4 cycles → rsp_* stable; cmd_ready=0 throughout; next command accepted the cycle after the rsp handshake.
- Reset mid-read: srstn=0 while arvalid=1 → next edge arvalid=0, cmd_ready=1, no rsp_valid; a following read completes normally.
- Randomized slave ready/valid delays on 1000 mixed transactions → every response matches its command in order; no valid drops before its handshake.
